// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis constants shared by the K=7 encoder and the Viterbi decoder
//   K        constraint length
//   STATE_W  shift-register / trellis state width (K-1)
//   TAIL_LEN number of zero tail bits that flush the encoder back to state 0
//   G0_DEF / G1_DEF generator polynomials; MSB taps the current input bit
package viterbi_pkg;
    localparam int K = 7;
    localparam int STATE_W = K - 1;
    localparam int TAIL_LEN = K - 1;
    localparam logic [K-1:0] G0_DEF = 7'o171;
    localparam logic [K-1:0] G1_DEF = 7'o133;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational single step of the convolutional code trellis
//   u       in   current input bit
//   sr      in   shift register, sr[K-2] is the most recent past bit
//   c0, c1  out  generator G0 / G1 parity of the window {u, sr}
//   next_sr out  shift register after this step
module conv_enc_core #(
    parameter int K = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0_DEF,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1_DEF
) (
    input  logic         u,
    input  logic [K-2:0] sr,
    output logic         c0,
    output logic         c1,
    output logic [K-2:0] next_sr
);
    logic [K-1:0] w;
    assign w = {u, sr};
    assign c0 = ^(w & G0);
    assign c1 = ^(w & G1);
    assign next_sr = w[K-1:1];
endmodule

// File: rtl/conv_enc_k7.sv
// conv_enc_k7: rate-1/2 K=7 convolutional encoder with optional zero-tail termination
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     input bit handshake; s_data bit, s_last ends the frame
//   m_valid/m_ready     coded pair handshake; m_pair = {G0, G1}, m_last ends the frame
//   enc_state           current shift-register contents
module conv_enc_k7 #(
    parameter int K = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0_DEF,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1_DEF,
    parameter bit TAIL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [1:0]   m_pair,
    output logic         m_last,
    output logic [K-2:0] enc_state
);
    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] TAIL_MAX = CW'(K - 2);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] tail_cnt_q, tail_cnt_d;
    logic [K-2:0]  sr_q, sr_d;
    logic          m_valid_q, m_valid_d;
    logic [1:0]    m_pair_q, m_pair_d;
    logic          m_last_q, m_last_d;
    logic          in_tail, step_en, take, tail_end, u, c0, c1;
    logic [K-2:0]  next_sr;

    assign in_tail = state_q == ST_TAIL;
    assign tail_end = in_tail && tail_cnt_q == TAIL_MAX;
    // The output register is free or being drained this cycle.
    assign step_en = !m_valid_q || m_ready;
    assign s_ready = !rst && !in_tail && step_en;
    // Tail steps need no input; data steps need a completed input handshake.
    assign take = in_tail ? step_en : s_valid && s_ready;
    assign u = !in_tail && s_data;

    conv_enc_core #(.K(K), .G0(G0), .G1(G1)) u_core (
        .u       (u),
        .sr      (sr_q),
        .c0      (c0),
        .c1      (c1),
        .next_sr (next_sr)
    );

    always_comb begin
        sr_d = take ? next_sr : sr_q;
        m_pair_d = take ? {c0, c1} : m_pair_q;
        m_valid_d = take || (m_valid_q && !m_ready);
        m_last_d = take ? (in_tail ? tail_end : s_last && !TAIL_EN) : m_last_q && !m_ready;
        state_d = !take ? state_q : in_tail ? (tail_end ? ST_DATA : ST_TAIL) : (s_last && TAIL_EN ? ST_TAIL : ST_DATA);
        tail_cnt_d = !(take && in_tail) ? tail_cnt_q : tail_end ? '0 : tail_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DATA;
            tail_cnt_q <= '0;
            sr_q <= '0;
            m_valid_q <= 1'b0;
            m_pair_q <= 2'b00;
            m_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tail_cnt_q <= tail_cnt_d;
            sr_q <= sr_d;
            m_valid_q <= m_valid_d;
            m_pair_q <= m_pair_d;
            m_last_q <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_pair = m_pair_q;
    assign m_last = m_last_q;
    assign enc_state = sr_q;
endmodule
